// File: rtl/line_clear_ctrl_pkg.sv
// Shared board geometry defaults and bit-layout helpers for the
// line clear controller.
package line_clear_ctrl_pkg;

   localparam int DEF_COLS  = 10;
   localparam int DEF_ROWS  = 20;
   localparam int DEF_FLASH = 25000000;

   // Cell (r,c) lives at bit r*cols+c; a row is a cols-wide slice.
   function automatic int row_lsb(input int r, input int cols);
      return r * cols;
   endfunction

   function automatic int cell_idx(input int r, input int c, input int cols);
      return r * cols + c;
   endfunction

endpackage

// File: rtl/line_clear_ctrl_row_full_detect.sv
// Combinational detector: a row is full when every cell is filled.
module row_full_detect #(
   parameter int BOARD_COLS = 10
) (
   input  logic [BOARD_COLS-1:0] row,
   output logic                  full
);

   always_comb full = &row;

endmodule

// File: rtl/line_clear_ctrl.sv
// Scans a captured board bottom-up, drops full rows, compacts the rest
// toward the bottom and holds the cleared rows for a display blink.
module line_clear_ctrl
   import line_clear_ctrl_pkg::*;
#(
   parameter int  BOARD_COLS   = DEF_COLS,
   parameter int  BOARD_ROWS   = DEF_ROWS,
   parameter int  FLASH_CYCLES = DEF_FLASH,
   localparam int BOARD_SIZE   = BOARD_COLS * BOARD_ROWS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [BOARD_SIZE-1:0] board_in,
   output logic                  busy,
   output logic                  flashing,
   output logic [BOARD_ROWS-1:0] clear_mask,
   output logic [BOARD_SIZE-1:0] board_out,
   output logic [4:0]            lines_cleared,
   output logic                  done
);

   localparam int RW = (BOARD_ROWS > 1) ? $clog2(BOARD_ROWS) : 1;
   localparam int FW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
   localparam logic [RW-1:0] LAST_ROW   = RW'(BOARD_ROWS - 1);
   localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_FLASH,
      S_DONE
   } state_t;

   state_t                  state;
   logic [BOARD_SIZE-1:0]   work;
   logic [RW-1:0]           rd;
   logic [RW-1:0]           wr;
   logic [FW-1:0]           flash_cnt;
   logic [BOARD_COLS-1:0]   cur_row;
   logic                    row_full;
   logic [4:0]              lines_next;

   always_comb cur_row = work[row_lsb(int'(rd), BOARD_COLS) +: BOARD_COLS];

   row_full_detect #(
      .BOARD_COLS(BOARD_COLS)
   ) u_full (
      .row  (cur_row),
      .full (row_full)
   );

   // Count including the row being scanned, so the last row decides FLASH.
   always_comb lines_next = lines_cleared + {4'b0, row_full};

   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= S_IDLE;
         work          <= '0;
         rd            <= '0;
         wr            <= '0;
         flash_cnt     <= '0;
         busy          <= 1'b0;
         flashing      <= 1'b0;
         done          <= 1'b0;
         clear_mask    <= '0;
         board_out     <= '0;
         lines_cleared <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  work          <= board_in;
                  board_out     <= '0;
                  clear_mask    <= '0;
                  lines_cleared <= '0;
                  rd            <= LAST_ROW;
                  wr            <= LAST_ROW;
                  busy          <= 1'b1;
                  state         <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (row_full) begin
                  clear_mask[rd] <= 1'b1;
                  lines_cleared  <= lines_next;
               end else begin
                  board_out[row_lsb(int'(wr), BOARD_COLS) +: BOARD_COLS]
                     <= cur_row;
                  if (wr != '0) wr <= wr - 1'b1;
               end
               if (rd != '0) begin
                  rd <= rd - 1'b1;
               end else if (lines_next != '0) begin
                  flash_cnt <= '0;
                  flashing  <= 1'b1;
                  state     <= S_FLASH;
               end else begin
                  done  <= 1'b1;
                  state <= S_DONE;
               end
            end
            S_FLASH: begin
               if (flash_cnt == FLASH_LAST) begin
                  flashing <= 1'b0;
                  done     <= 1'b1;
                  state    <= S_DONE;
               end else begin
                  flash_cnt <= flash_cnt + 1'b1;
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Self-checking bench for line_clear_ctrl against a row-list model.
module tb_line_clear_ctrl;

   localparam int C = 10;
   localparam int R = 20;
   localparam int F = 4;
   localparam int S = C * R;
   localparam int WIN = 60;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [S-1:0] board_in = '0;
   logic         busy;
   logic         flashing;
   logic         done;
   logic [R-1:0] clear_mask;
   logic [S-1:0] board_out;
   logic [4:0]   lines_cleared;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   line_clear_ctrl #(
      .BOARD_COLS(C),
      .BOARD_ROWS(R),
      .FLASH_CYCLES(F)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .board_in     (board_in),
      .busy         (busy),
      .flashing     (flashing),
      .clear_mask   (clear_mask),
      .board_out    (board_out),
      .lines_cleared(lines_cleared),
      .done         (done)
   );

   function automatic logic [S-1:0] full_row(input int r);
      logic [S-1:0] v;
      v = '0;
      for (int c = 0; c < C; c++) v[r*C+c] = 1'b1;
      return v;
   endfunction

   function automatic logic [S-1:0] bit_at(input int i);
      logic [S-1:0] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   // Keep the non-full rows in top-to-bottom order, stack them at the bottom.
   function automatic void model(input logic [S-1:0] b,
                                 output logic [S-1:0] o,
                                 output logic [R-1:0] m,
                                 output int n);
      logic [C-1:0] keep[$];
      logic [C-1:0] row;
      int base;
      o = '0;
      m = '0;
      n = 0;
      for (int r = 0; r < R; r++) begin
         row = b[r*C +: C];
         if (row == {C{1'b1}}) begin
            m[r] = 1'b1;
            n++;
         end else begin
            keep.push_back(row);
         end
      end
      base = R - keep.size();
      for (int i = 0; i < keep.size(); i++) o[(base+i)*C +: C] = keep[i];
   endfunction

   function automatic int exp_latency(input int n);
      return (n == 0) ? R + 1 : R + F + 1;
   endfunction

   // Start one operation and observe a fixed window of cycles afterwards.
   task automatic run_op(input logic [S-1:0] b,
                         input int extra_start_at,
                         input int swap_at,
                         input logic [S-1:0] alt,
                         output int done_at,
                         output int dones,
                         output int flashes,
                         output bit busy_ok);
      @(negedge clk);
      board_in = b;
      start = 1'b1;
      @(posedge clk);
      done_at = -1;
      dones = 0;
      flashes = 0;
      busy_ok = 1'b1;
      for (int n = 1; n <= WIN; n++) begin
         @(negedge clk);
         start = (n == extra_start_at);
         if (n == swap_at) board_in = alt;
         if (done) begin
            dones++;
            if (done_at < 0) done_at = n;
         end
         if (flashing) flashes++;
         if (done_at < 0 && !busy) busy_ok = 1'b0;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      start = 1'b1;
      board_in = '1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy: got %b expected 0", busy);
      end
      checks++;
      if (flashing !== 1'b0) begin
         errors++;
         $display("FAIL reset_flashing: got %b expected 0", flashing);
      end
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL reset_done: got %b expected 0", done);
      end
      checks++;
      if (board_out !== '0) begin
         errors++;
         $display("FAIL reset_board_out: got %0h expected 0", board_out);
      end
      checks++;
      if (clear_mask !== '0 || lines_cleared !== 5'd0) begin
         errors++;
         $display("FAIL reset_counts: got mask %0h lines %0d expected 0 0",
                  clear_mask, lines_cleared);
      end
      start = 1'b0;
      board_in = '0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_busy: got %b expected 0", busy);
      end
   endtask

   task automatic test_empty();
      int d, nd, fl;
      bit bo;
      run_op('0, 0, 0, '0, d, nd, fl, bo);
      checks++;
      if (d !== R + 1) begin
         errors++;
         $display("FAIL empty_latency: got %0d expected %0d", d, R + 1);
      end
      checks++;
      if (fl !== 0) begin
         errors++;
         $display("FAIL empty_flash: got %0d expected 0", fl);
      end
      checks++;
      if (board_out !== '0 || clear_mask !== '0 || lines_cleared !== 5'd0) begin
         errors++;
         $display("FAIL empty_result: got out %0h mask %0h lines %0d expected 0",
                  board_out, clear_mask, lines_cleared);
      end
      checks++;
      if (nd !== 1 || !bo) begin
         errors++;
         $display("FAIL empty_done_busy: got dones %0d busy_ok %0d expected 1 1",
                  nd, bo);
      end
   endtask

   task automatic test_clears();
      logic [S-1:0] pat[3];
      logic [S-1:0] want_out[3];
      logic [R-1:0] want_mask[3];
      int           want_n[3];
      logic [S-1:0] mo;
      logic [R-1:0] mm;
      int mn, d, nd, fl;
      bit bo;
      pat[0] = full_row(19) | bit_at(185);
      pat[1] = full_row(16) | full_row(17) | full_row(18) | full_row(19)
             | bit_at(150) | bit_at(155);
      pat[2] = full_row(19) | full_row(17) | bit_at(180);
      want_out[0] = bit_at(195);
      want_out[1] = bit_at(190) | bit_at(195);
      want_out[2] = bit_at(190);
      want_mask[0] = 20'h80000;
      want_mask[1] = 20'hF0000;
      want_mask[2] = 20'hA0000;
      want_n[0] = 1;
      want_n[1] = 4;
      want_n[2] = 2;
      for (int k = 0; k < 3; k++) begin
         model(pat[k], mo, mm, mn);
         run_op(pat[k], 0, 0, '0, d, nd, fl, bo);
         checks++;
         if (d !== R + F + 1 || fl !== F) begin
            errors++;
            $display("FAIL clear%0d_timing: got done %0d flash %0d expected %0d %0d",
                     k, d, fl, R + F + 1, F);
         end
         checks++;
         if (board_out !== want_out[k] || board_out !== mo) begin
            errors++;
            $display("FAIL clear%0d_board: got %0h expected %0h",
                     k, board_out, want_out[k]);
         end
         checks++;
         if (clear_mask !== want_mask[k] || clear_mask !== mm) begin
            errors++;
            $display("FAIL clear%0d_mask: got %0h expected %0h",
                     k, clear_mask, want_mask[k]);
         end
         checks++;
         if (int'(lines_cleared) !== want_n[k] || nd !== 1) begin
            errors++;
            $display("FAIL clear%0d_lines: got %0d dones %0d expected %0d 1",
                     k, lines_cleared, nd, want_n[k]);
         end
      end
   endtask

   task automatic test_ignore_start();
      logic [S-1:0] b, mo;
      logic [R-1:0] mm;
      int mn, d, nd, fl;
      bit bo;
      b = full_row(19) | full_row(10) | bit_at(33) | bit_at(118);
      model(b, mo, mm, mn);
      run_op(b, 5, 3, '0, d, nd, fl, bo);
      checks++;
      if (board_out !== mo || clear_mask !== mm) begin
         errors++;
         $display("FAIL ignore_board: got %0h mask %0h expected %0h mask %0h",
                  board_out, clear_mask, mo, mm);
      end
      checks++;
      if (nd !== 1 || d !== exp_latency(mn)) begin
         errors++;
         $display("FAIL ignore_done: got dones %0d at %0d expected 1 at %0d",
                  nd, d, exp_latency(mn));
      end
   endtask

   task automatic test_reset_flash();
      logic [S-1:0] b, mo;
      logic [R-1:0] mm;
      int mn, d, nd, fl;
      int late;
      bit bo;
      b = full_row(19) | bit_at(185);
      @(negedge clk);
      board_in = b;
      start = 1'b1;
      @(posedge clk);
      late = 0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         start = 1'b0;
         if (n == 21) begin
            checks++;
            if (flashing !== 1'b1) begin
               errors++;
               $display("FAIL abort_in_flash: got %b expected 1", flashing);
            end
            rst = 1'b0;
         end
         if (n == 22) begin
            checks++;
            if (busy !== 1'b0 || flashing !== 1'b0 || done !== 1'b0 ||
                board_out !== '0 || clear_mask !== '0 || lines_cleared !== 5'd0) begin
               errors++;
               $display("FAIL abort_outputs: got busy %b flash %b done %b out %0h mask %0h lines %0d expected all 0",
                        busy, flashing, done, board_out, clear_mask, lines_cleared);
            end
            rst = 1'b1;
         end
         if (n > 21 && (done || busy)) late++;
      end
      checks++;
      if (late !== 0) begin
         errors++;
         $display("FAIL abort_no_done: got %0d active cycles expected 0", late);
      end
      b = full_row(0) | bit_at(57);
      model(b, mo, mm, mn);
      run_op(b, 0, 0, '0, d, nd, fl, bo);
      checks++;
      if (board_out !== mo || clear_mask !== mm || d !== exp_latency(mn)) begin
         errors++;
         $display("FAIL abort_rerun: got %0h mask %0h done %0d expected %0h mask %0h done %0d",
                  board_out, clear_mask, d, mo, mm, exp_latency(mn));
      end
   endtask

   task automatic test_random();
      logic [S-1:0] b, alt, mo;
      logic [R-1:0] mm;
      int mn, d, nd, fl;
      bit bo;
      for (int it = 0; it < 10; it++) begin
         b = '0;
         for (int r = 0; r < R; r++) begin
            if ($urandom_range(0, 2) == 0) b |= full_row(r);
            else
               for (int c = 0; c < C; c++)
                  if ($urandom_range(0, 1) == 1) b[r*C+c] = 1'b1;
         end
         alt = '0;
         for (int w = 0; w < S; w++) alt[w] = 1'($urandom_range(0, 1));
         model(b, mo, mm, mn);
         run_op(b, 0, $urandom_range(1, 15), alt, d, nd, fl, bo);
         checks++;
         if (board_out !== mo || clear_mask !== mm || int'(lines_cleared) !== mn) begin
            errors++;
            $display("FAIL rand%0d_result: got %0h mask %0h lines %0d expected %0h mask %0h lines %0d",
                     it, board_out, clear_mask, lines_cleared, mo, mm, mn);
         end
         checks++;
         if (d !== exp_latency(mn) || nd !== 1 || fl !== (mn == 0 ? 0 : F) || !bo) begin
            errors++;
            $display("FAIL rand%0d_timing: got done %0d dones %0d flash %0d busy_ok %0d expected %0d 1 %0d 1",
                     it, d, nd, fl, bo, exp_latency(mn), (mn == 0 ? 0 : F));
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [S-1:0] a, b, mo;
      logic [R-1:0] mm;
      int mn, d1, d2, nd;
      a = full_row(19);
      b = bit_at(7) | bit_at(112) | full_row(2) & ~bit_at(21);
      model(b, mo, mm, mn);
      @(negedge clk);
      board_in = a;
      start = 1'b1;
      @(posedge clk);
      d1 = -1;
      d2 = -1;
      nd = 0;
      for (int n = 1; n <= 90; n++) begin
         @(negedge clk);
         if (done) begin
            nd++;
            if (d1 < 0) begin
               d1 = n;
               board_in = b;
            end else if (d2 < 0) begin
               d2 = n;
               start = 1'b0;
            end
         end
      end
      start = 1'b0;
      checks++;
      if (d1 !== R + F + 1) begin
         errors++;
         $display("FAIL b2b_first: got %0d expected %0d", d1, R + F + 1);
      end
      checks++;
      if (d2 !== R + F + 1 + 1 + exp_latency(mn) || nd !== 2) begin
         errors++;
         $display("FAIL b2b_second: got %0d dones %0d expected %0d 2",
                  d2, nd, R + F + 2 + exp_latency(mn));
      end
      checks++;
      if (board_out !== mo || clear_mask !== mm) begin
         errors++;
         $display("FAIL b2b_result: got %0h mask %0h expected %0h mask %0h",
                  board_out, clear_mask, mo, mm);
      end
   endtask

   initial begin
      test_reset();
      test_empty();
      test_clears();
      test_ignore_start();
      test_reset_flash();
      test_random();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/line_clear_ctrl.md
LINE_CLEAR_CTRL -- requirements
Module: line_clear_ctrl

Interface
REQ-001 SHALL have parameter BOARD_COLS, default 10, cells per row.
REQ-002 SHALL have parameter BOARD_ROWS, default 20, rows per board; row 0 top, row BOARD_ROWS-1 bottom.
REQ-003 SHALL have parameter FLASH_CYCLES, default 25000000, cycles that cleared rows are held for display blink; legal range 1 and up.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  request to compact board_in; sampled only in IDLE.
REQ-007 board_in  input  BOARD_SIZE  board snapshot; cell (r,c) at bit r*BOARD_COLS+c; 1 = filled.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 flashing  output  1  high during FLASH only.
REQ-010 clear_mask  output  BOARD_ROWS  bit r set = row r was full in the captured snapshot.
REQ-011 board_out  output  BOARD_SIZE  compacted board, same bit layout as board_in.
REQ-012 lines_cleared  output  5  count of full rows in the captured snapshot (0..BOARD_ROWS).
REQ-013 done  output  1  one-cycle pulse; board_out, lines_cleared and clear_mask are valid and held until the next accepted start.

Function
REQ-014 States SHALL be IDLE, SCAN, FLASH and DONE; encoding is free.
REQ-015 IDLE with start=1 SHALL capture board_in into an internal work register, zero board_out, clear_mask and lines_cleared, set rd=wr=BOARD_ROWS-1, and go to SCAN.
REQ-016 start SHALL be ignored when not in IDLE; board_in changes after capture SHALL have no effect.
REQ-017 Each SCAN cycle SHALL process exactly one row rd.
REQ-018 In SCAN, if row rd of the work register is all ones, the block SHALL set clear_mask[rd] and increment lines_cleared, leaving wr unchanged.
REQ-019 In SCAN, if row rd is not all ones, the block SHALL copy it to board_out row wr and decrement wr.
REQ-020 In SCAN, rd SHALL decrement every cycle.
REQ-021 When SCAN processes rd==0, the next state SHALL be FLASH if lines_cleared (including this cycle's row) is nonzero, else DONE.
REQ-022 Rows above the final wr SHALL remain zero (empty); relative order of non-full rows SHALL be preserved.
REQ-023 FLASH SHALL last exactly FLASH_CYCLES cycles, counted by an internal counter cleared on FLASH entry, then go to DONE.
REQ-024 DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-025 Latency: with start accepted at edge t, SCAN occupies cycles t+1..t+BOARD_ROWS.
REQ-026 done SHALL be high in cycle t+BOARD_ROWS+1 when nothing is cleared, else in cycle t+BOARD_ROWS+FLASH_CYCLES+1.
REQ-027 start held high continuously SHALL start a new operation in the first IDLE cycle after DONE.
REQ-028 rd and wr SHALL be sized $clog2(BOARD_ROWS) bits; rd and wr SHALL never wrap below 0.

Reset
REQ-029 While rst=0 at a rising edge, the state SHALL go to IDLE.
REQ-030 While rst=0 at a rising edge, busy, flashing and done SHALL be 0.
REQ-031 While rst=0 at a rising edge, board_out, clear_mask, lines_cleared, the work register and all counters SHALL be 0.
REQ-032 Reset asserted mid-SCAN or mid-FLASH SHALL abort the operation with no done pulse.

Structure
REQ-033 BOARD_COLS, BOARD_ROWS, BOARD_SIZE and the row-slice and cell-index macros SHALL live in shared header.v; state encodings stay local.
REQ-034 Full-row detection SHALL be a natural sub-module row_full_detect (BOARD_COLS-bit AND-reduce, combinational); no other sub-modules.

Verification (BOARD_COLS=10, BOARD_ROWS=20, FLASH_CYCLES=4)
REQ-035 Empty board, start -> done at t+21, lines_cleared=0, clear_mask=0, board_out=0, flashing never high.
REQ-036 Row 19 full plus bit 185 set, start -> flashing for 4 cycles, done at t+25, lines_cleared=1, clear_mask=bit 19, board_out has only bit 195 set.
REQ-037 Rows 16-19 full with bits 150 and 155 set -> lines_cleared=4, clear_mask=0xF0000, board_out has only bits 190 and 195 set.
REQ-038 Rows 19 and 17 full, row 18 = bit 180 -> lines_cleared=2, board_out has only bit 190 set.
REQ-039 Second start pulse during SCAN, and board_in changed during SCAN -> both ignored, results match the first snapshot, exactly one done.
REQ-040 rst=0 during FLASH cycle 2 -> next cycle all outputs 0, state IDLE, no done; a subsequent start completes normally.
